// File: rtl/rv32c_aligner_pkg.sv
// Shared types and constants for the RV32C fetch realignment buffer.
package rv32c_aligner_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } aligner_state_t;

    typedef logic [15:0] halfword_t;

    localparam int         BUF_HW        = 4;
    localparam int         CNT_W         = 3;
    localparam logic [1:0] C_OPCODE_FULL = 2'b11;

    // A halfword starts a 16-bit instruction unless its low two bits are 11.
    function automatic logic hw_is_compressed(input halfword_t hw);
        return (hw[1:0] != C_OPCODE_FULL);
    endfunction

endpackage

// File: rtl/rv32c_hw_queue.sv
// Four-entry halfword shift queue. Entry 0 is always the oldest halfword.
// A pop of one or two entries and a push of one or two entries may happen
// in the same cycle; clear wins over both.
module rv32c_hw_queue
    import rv32c_aligner_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push1,
    input  logic             push2,
    input  halfword_t        push_hw0,
    input  halfword_t        push_hw1,
    input  logic             pop1,
    input  logic             pop2,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output halfword_t        hw0,
    output halfword_t        hw1
);

    halfword_t        hw_r     [BUF_HW];
    halfword_t        hw_nxt_s [BUF_HW];
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] pop_n_s;
    logic [CNT_W-1:0] base_s;
    logic [CNT_W-1:0] src_s;

    // Shift out popped entries, then write pushed halfwords behind the survivors.
    always_comb begin
        hw_nxt_s = hw_r;
        src_s    = 3'd0;
        if (pop2) begin
            pop_n_s = 3'd2;
        end else if (pop1) begin
            pop_n_s = 3'd1;
        end else begin
            pop_n_s = 3'd0;
        end
        base_s = cnt_r - pop_n_s;
        for (int i = 0; i < BUF_HW; i++) begin
            src_s = CNT_W'(i) + pop_n_s;
            if (clear) begin
                hw_nxt_s[i] = 16'h0000;
            end else if ((push1 || push2) && (CNT_W'(i) == base_s)) begin
                hw_nxt_s[i] = push_hw0;
            end else if (push2 && (CNT_W'(i) == (base_s + 3'd1))) begin
                hw_nxt_s[i] = push_hw1;
            end else if (src_s < CNT_W'(BUF_HW)) begin
                hw_nxt_s[i] = hw_r[src_s[1:0]];
            end else begin
                hw_nxt_s[i] = 16'h0000;
            end
        end
        if (clear) begin
            cnt_nxt_s = 3'd0;
        end else if (push2) begin
            cnt_nxt_s = base_s + 3'd2;
        end else if (push1) begin
            cnt_nxt_s = base_s + 3'd1;
        end else begin
            cnt_nxt_s = base_s;
        end
    end

    // Queue storage and occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_HW; i++) begin
                hw_r[i] <= 16'h0000;
            end
            cnt_r <= 3'd0;
        end else begin
            hw_r  <= hw_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign hw0 = hw_r[0];
    assign hw1 = hw_r[1];

endmodule

// File: rtl/rv32c_fetch_aligner.sv
// RV32C fetch realignment buffer: pulls aligned words from imem and hands
// decode one 16- or 32-bit instruction per handshake, including 32-bit
// instructions that straddle a word boundary.
// Optional macro RV32C_ALIGNER_ILLEGAL_EN adds inst_illegal, flagging the
// all-zero compressed encoding.
module rv32c_fetch_aligner
    import rv32c_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busy,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
`ifdef RV32C_ALIGNER_ILLEGAL_EN
   ,output logic        inst_illegal
`endif
);

    aligner_state_t   state_r, state_nxt_s;
    logic             go_r;
    logic [31:0]      head_pc_r, head_pc_nxt_s;
    logic [31:0]      fetch_addr_r, fetch_addr_nxt_s;
    logic [31:0]      flush_addr_r, flush_addr_nxt_s;
    logic             skip_low_r, skip_low_nxt_s;
    logic [CNT_W-1:0] q_cnt_s;
    halfword_t        q_hw0_s, q_hw1_s;
    logic             is_c_s, valid_s, consume_s, append_s, room_s;
    logic [3:0]       fill_s;
    logic             unused_ok_s;

    assign unused_ok_s = redirect_pc[0];

    rv32c_hw_queue u_queue (
        .clk      (clk),
        .rst      (rst),
        .push1    (append_s & skip_low_r),
        .push2    (append_s & ~skip_low_r),
        .push_hw0 (skip_low_r ? imem_rdata[31:16] : imem_rdata[15:0]),
        .push_hw1 (imem_rdata[31:16]),
        .pop1     (consume_s & is_c_s),
        .pop2     (consume_s & ~is_c_s),
        .clear    (redirect),
        .cnt      (q_cnt_s),
        .hw0      (q_hw0_s),
        .hw1      (q_hw1_s)
    );

    // Instruction presence at the queue head and the handshake events.
    always_comb begin
        is_c_s = hw_is_compressed(q_hw0_s);
        if ((state_r == RUN) &&
            (((q_cnt_s >= 3'd1) && is_c_s) || ((q_cnt_s >= 3'd2) && !is_c_s))) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
        consume_s = valid_s & inst_ready & ~redirect;
        append_s  = imem_ren & ~imem_busy & (state_r == RUN) & ~redirect;
    end

    // Read request: a flush drains the old request; otherwise ask only when the words fit.
    always_comb begin
        fill_s = {1'b0, q_cnt_s} + (skip_low_r ? 4'd1 : 4'd2);
        room_s = (fill_s <= 4'd4);
        if (!go_r) begin
            imem_ren  = 1'b0;
            imem_addr = fetch_addr_r;
        end else begin
            case (state_r)
                RUN: begin
                    imem_ren  = room_s;
                    imem_addr = fetch_addr_r;
                end
                FLUSH: begin
                    imem_ren  = 1'b1;
                    imem_addr = flush_addr_r;
                end
                default: begin
                    imem_ren  = 1'b0;
                    imem_addr = fetch_addr_r;
                end
            endcase
        end
    end

    // Next-state for PCs, fetch pointer and FSM; redirect overrides everything.
    always_comb begin
        head_pc_nxt_s    = head_pc_r;
        fetch_addr_nxt_s = fetch_addr_r;
        skip_low_nxt_s   = skip_low_r;
        flush_addr_nxt_s = flush_addr_r;
        state_nxt_s      = state_r;
        if (redirect) begin
            head_pc_nxt_s    = {redirect_pc[31:1], 1'b0};
            fetch_addr_nxt_s = {redirect_pc[31:2], 2'b00};
            skip_low_nxt_s   = redirect_pc[1];
        end else begin
            if (consume_s) begin
                head_pc_nxt_s = head_pc_r + (is_c_s ? 32'd2 : 32'd4);
            end else begin
                head_pc_nxt_s = head_pc_r;
            end
            if (append_s) begin
                fetch_addr_nxt_s = fetch_addr_r + 32'd4;
                skip_low_nxt_s   = 1'b0;
            end else begin
                fetch_addr_nxt_s = fetch_addr_r;
            end
        end
        case (state_r)
            RUN: begin
                if (redirect && imem_ren && imem_busy) begin
                    state_nxt_s      = FLUSH;
                    flush_addr_nxt_s = fetch_addr_r;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                if (!imem_busy) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= RUN;
            go_r         <= 1'b0;
            head_pc_r    <= RESET_PC;
            fetch_addr_r <= {RESET_PC[31:2], 2'b00};
            flush_addr_r <= {RESET_PC[31:2], 2'b00};
            skip_low_r   <= RESET_PC[1];
        end else begin
            state_r      <= state_nxt_s;
            go_r         <= 1'b1;
            head_pc_r    <= head_pc_nxt_s;
            fetch_addr_r <= fetch_addr_nxt_s;
            flush_addr_r <= flush_addr_nxt_s;
            skip_low_r   <= skip_low_nxt_s;
        end
    end

    // Instruction outputs, forced to zero while nothing valid is presented.
    always_comb begin
        inst_valid = valid_s;
        inst_pc    = head_pc_r;
        if (valid_s) begin
            inst      = is_c_s ? {16'h0000, q_hw0_s} : {q_hw1_s, q_hw0_s};
            inst_is_c = is_c_s;
        end else begin
            inst      = 32'h0000_0000;
            inst_is_c = 1'b0;
        end
`ifdef RV32C_ALIGNER_ILLEGAL_EN
        inst_illegal = valid_s & is_c_s & (q_hw0_s == 16'h0000);
`endif
    end

endmodule

// File: doc/rv32c_fetch_aligner.md
Name: rv32c_fetch_aligner

Overview:
- Fetch-side realignment buffer for the RV32C path. It sits between the word-aligned instruction-memory port and the decompressor/decode stage.
- Pulls 32-bit aligned words from imem and holds them as halfwords.
- Presents exactly one instruction per handshake: 16-bit (compressed) or 32-bit, including 32-bit instructions straddling a word boundary.
- Handles PC redirects to halfword-aligned targets.

Parameters:
- RESET_PC, 32'h0000_0200, PC loaded at reset; must be halfword aligned.
- BUF_HW, 4, halfword buffer depth; fixed at 4, other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- imem_ren  out  1  word read request; held until accepted
- imem_addr  out  32  word-aligned fetch address, bits[1:0]=0
- imem_rdata  in  32  read data, valid in the cycle imem_busy=0 with imem_ren=1
- imem_busy  in  1  request not yet complete
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new PC; bit0 ignored
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts instruction
- inst  out  32  raw instruction; compressed form zero-extended in [15:0]
- inst_pc  out  32  PC of inst
- inst_is_c  out  1  inst is 16-bit

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - cnt=0, head_pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}, skip_low=RESET_PC[1], state=RUN.
  - Outputs: imem_ren=0, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_is_c=0.
  - Reset deasserting mid-transaction abandons it; no stale data is ever buffered.
- Storage:
  - hw[0..3] halfwords, cnt in 0..4. hw[0] is at head_pc.
- Fetch, state RUN:
  - imem_ren=1 when cnt + incoming halfwords ≤ 4. Incoming is 2, or 1 when skip_low.
  - Evaluate cnt after any same-cycle consume; combinational from registered cnt is acceptable if it never overflows.
  - Completion (imem_ren & ~imem_busy):
    - Append rdata[15:0] then rdata[31:16], or only rdata[31:16] if skip_low.
    - Clear skip_low; fetch_addr += 4 (wraps mod 2^32).
  - imem_addr stays stable while imem_ren & imem_busy.
- Output:
  - is_c = hw[0][1:0] != 2'b11.
  - inst_valid = (cnt≥1 & is_c) | (cnt≥2 & ~is_c).
  - inst = is_c ? {16'h0,hw[0]} : {hw[1],hw[0]}; inst_pc=head_pc; inst_is_c=is_c.
  - Outputs are combinational from buffer state; no fetch-to-output bypass.
  - Latency: redirect → first inst_valid is 2 cycles minimum (request cycle, then data registered).
- Consume (inst_valid & inst_ready):
  - Shift buffer by 1 (is_c) or 2 halfwords; head_pc += 2 or 4.
  - Append and consume in the same cycle are both applied: new cnt = cnt - consumed + appended.
- Redirect, highest priority:
  - Buffer cleared (cnt=0), head_pc={redirect_pc[31:1],1'b0}, fetch_addr={redirect_pc[31:2],2'b00}, skip_low=redirect_pc[1].
  - Any same-cycle consume or append is discarded.
  - If imem_ren & imem_busy that cycle → state FLUSH. Otherwise stay in RUN.
- FLUSH state:
  - Keep imem_ren=1 and the old imem_addr until ~imem_busy. Discard the data, then go to RUN.
  - A new redirect in FLUSH updates the target registers and stays in FLUSH.
  - inst_valid=0 in FLUSH.
- Stall: inst_ready=0 with a full buffer → imem_ren deasserts only between transactions, never mid-transaction.

Optional Feature:
- RV32C_ALIGNER_ILLEGAL_EN:
  - Adds output inst_illegal (1 bit).
  - Asserted with inst_valid when is_c and hw[0]==16'h0000 (defined-illegal encoding).
  - Reset value 0.
- Without the macro, the port is absent and all-zero halfwords pass through as compressed instructions.

Decomposition:
- Package rv32c_aligner_pkg holds:
  - aligner_state_t enum {RUN, FLUSH}
  - halfword_t (logic[15:0])
  - BUF_HW, C_OPCODE_FULL=2'b11
- One natural sub-module: rv32c_hw_queue, a 4-entry halfword shift queue. It takes push1/push2, pop1/pop2 and clear, and exposes cnt, hw0 and hw1.
- FSM, address counter and output muxing stay in the top module.

Test Plan:
- Reset, RESET_PC=0x200, memory {0x00A00093, 0x4501_4505}, always ready, inst_ready=1 → outputs in order:
  - 0x00A00093 @0x200, is_c=0
  - 0x4505 @0x204, is_c=1
  - 0x4501 @0x206, is_c=1
- Straddle: word@0x200=0x0093_4505, word@0x204=0x0000_00A0 → 0x4505 @0x200, then 0x00A00093 @0x202 (is_c=0). inst_valid stays low until the second word arrives.
- Redirect to 0x302 with word@0x300=0x4585_4501 → first output 0x4585 @0x302. The lower halfword is never presented.
- Redirect while imem_busy=1 for 3 cycles on addr 0x208 → imem_addr holds 0x208 until completion, that data is dropped, then fetch at the new target. No inst_valid during FLUSH.
- inst_ready=0 for 10 cycles with all-compressed stream → cnt saturates at 4 with no overflow. After release, 4 consecutive 16-bit outputs at PCs +2 apart.
- Feature enabled, word 0x0000_4505 → 0x4505 with inst_illegal=0, then 0x0000 with inst_illegal=1.
